lock_chamber_ctrl: RTL and testbench

Chamber sequencer for the boat lock. It consumes the synchronized arrive/depart request levels produced by the request front end. It drives the outer port, the inner port and the pressure-up/pressure-down actuators through a complete passage. It owns the chamber pressure state and refuses new requests until the current passage finishes.

---
 rtl/lock_pkg.sv | 25 ++
 rtl/lock_timer.sv | 28 ++
 rtl/lock_chamber_ctrl.sv | 126 ++++++++++++
 tb/tb_lock_chamber_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared types and defaults for the boat-lock chamber sequencer and its request front end.
package lock_pkg;

    // Chamber passage phases
    typedef enum logic [2:0] {
        StIdle,
        StPreAdj,
        StEntryOpen,
        StXferAdj,
        StExitOpen
    } lockState_e;

    // Passage direction, captured on leaving idle
    localparam logic DIR_ARRIVE = 1'b0;
    localparam logic DIR_DEPART = 1'b1;

    // Default phase lengths, also used by the request front end's pressure counters
    localparam int unsigned DEF_PRESS_CYCLES  = 8;
    localparam int unsigned DEF_STABLE_CYCLES = 4;

    function automatic int unsigned maxU(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Load/decrement countdown timer; done while the count sits at zero, never wraps.
module lock_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] loadVal,
    input  logic             dec,
    output logic             done
);

    logic [WIDTH-1:0] count;

    // Load has priority; decrement stops at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= loadVal;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/lock_chamber_ctrl.sv
// Chamber sequencer: runs one complete passage (pressure pre-adjust, entry door,
// transfer pressure change, exit door) per accepted request.
module lock_chamber_ctrl
    import lock_pkg::*;
#(
    parameter int unsigned PRESS_CYCLES  = DEF_PRESS_CYCLES,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic arrive_req,
    input  logic depart_req,
    input  logic occupied,
    output logic outer_open,
    output logic inner_open,
    output logic press_up,
    output logic press_down,
    output logic busy,
    output logic level_hi
);

    localparam int unsigned CNT_W = $clog2(maxU(PRESS_CYCLES, STABLE_CYCLES) + 1);
    localparam logic [CNT_W-1:0] PRESS_LOAD  = CNT_W'(PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LOAD = CNT_W'(STABLE_CYCLES - 1);

    lockState_e stateQ, stateD;
    logic       dirQ, dirD;
    logic       levelD;
    logic       pressLoad, pressDec, pressDone;
    logic       stabLoad, stabDec, stabDone;

    // Next state, direction capture, level toggles and timer control
    always_comb begin
        stateD = stateQ;
        dirD   = dirQ;
        levelD = level_hi;
        unique case (stateQ)
            StIdle: begin
                if (arrive_req) begin
                    dirD   = DIR_ARRIVE;
                    stateD = level_hi ? StPreAdj : StEntryOpen;
                end else if (depart_req) begin
                    dirD   = DIR_DEPART;
                    stateD = level_hi ? StEntryOpen : StPreAdj;
                end
            end
            StPreAdj: begin
                if (pressDone) begin
                    levelD = ~level_hi;
                    stateD = StEntryOpen;
                end
            end
            StEntryOpen: begin
                if (occupied && stabDone) stateD = StXferAdj;
            end
            StXferAdj: begin
                if (pressDone) begin
                    levelD = ~level_hi;
                    stateD = StExitOpen;
                end
            end
            StExitOpen: begin
                if (!occupied && stabDone) stateD = StIdle;
            end
            default: stateD = StIdle;
        endcase

        pressLoad = ((stateD == StPreAdj) || (stateD == StXferAdj)) && (stateD != stateQ);
        pressDec  = (stateQ == StPreAdj) || (stateQ == StXferAdj);
        // Stability restarts on entry and whenever the sensor disagrees with the wanted value
        stabLoad  = (((stateD == StEntryOpen) || (stateD == StExitOpen)) && (stateD != stateQ))
                  || ((stateQ == StEntryOpen) && !occupied)
                  || ((stateQ == StExitOpen) && occupied);
        stabDec   = (stateQ == StEntryOpen) || (stateQ == StExitOpen);
    end

    // State register with outputs registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ     <= StIdle;
            dirQ       <= DIR_ARRIVE;
            level_hi   <= 1'b1;
            outer_open <= 1'b0;
            inner_open <= 1'b0;
            press_up   <= 1'b0;
            press_down <= 1'b0;
            busy       <= 1'b0;
        end else begin
            stateQ     <= stateD;
            dirQ       <= dirD;
            level_hi   <= levelD;
            outer_open <= ((stateD == StEntryOpen) && (dirD == DIR_ARRIVE))
                       || ((stateD == StExitOpen) && (dirD == DIR_DEPART));
            inner_open <= ((stateD == StEntryOpen) && (dirD == DIR_DEPART))
                       || ((stateD == StExitOpen) && (dirD == DIR_ARRIVE));
            press_up   <= ((stateD == StPreAdj) && (dirD == DIR_DEPART))
                       || ((stateD == StXferAdj) && (dirD == DIR_ARRIVE));
            press_down <= ((stateD == StPreAdj) && (dirD == DIR_ARRIVE))
                       || ((stateD == StXferAdj) && (dirD == DIR_DEPART));
            busy       <= (stateD != StIdle);
        end
    end

    lock_timer #(
        .WIDTH(CNT_W)
    ) pressTimer (
        .clk    (clk),
        .rst    (rst),
        .load   (pressLoad),
        .loadVal(PRESS_LOAD),
        .dec    (pressDec),
        .done   (pressDone)
    );

    lock_timer #(
        .WIDTH(CNT_W)
    ) stableTimer (
        .clk    (clk),
        .rst    (rst),
        .load   (stabLoad),
        .loadVal(STABLE_LOAD),
        .dec    (stabDec),
        .done   (stabDone)
    );

endmodule

// File: tb/tb_lock_chamber_ctrl.sv
// Bench for lock_chamber_ctrl: hand-derived vector table plus a cycle model feeding a scoreboard.
module tb_lock_chamber_ctrl;

    localparam int unsigned P = 8;
    localparam int unsigned S = 4;

    // Model phases
    localparam int M_IDLE = 0, M_PRE = 1, M_ENTRY = 2, M_XFER = 3, M_EXIT = 4;

    logic clk = 1'b0;
    logic rst, arrive_req, depart_req, occupied;
    logic outer_open, inner_open, press_up, press_down, busy, level_hi;

    always #5 clk = ~clk;

    lock_chamber_ctrl #(
        .PRESS_CYCLES (P),
        .STABLE_CYCLES(S)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .arrive_req(arrive_req),
        .depart_req(depart_req),
        .occupied  (occupied),
        .outer_open(outer_open),
        .inner_open(inner_open),
        .press_up  (press_up),
        .press_down(press_down),
        .busy      (busy),
        .level_hi  (level_hi)
    );

    // Output vector bits: {outer, inner, up, down, busy, level_hi}
    typedef struct {
        logic       a;
        logic       d;
        logic       o;
        int         n;
        logic [5:0] exp;
    } vec_t;

    int nCompared = 0;
    int nMismatched = 0;
    logic [5:0] expQ[$];

    int   mState, mPhase, mRun;
    logic mDir, mLvl;

    function automatic logic [5:0] dutOut();
        return {outer_open, inner_open, press_up, press_down, busy, level_hi};
    endfunction

    function automatic logic [5:0] modelOut();
        logic oo, io, pu, pd;
        oo = (mState == M_ENTRY && !mDir) || (mState == M_EXIT && mDir);
        io = (mState == M_ENTRY && mDir) || (mState == M_EXIT && !mDir);
        pu = (mState == M_PRE && mDir) || (mState == M_XFER && !mDir);
        pd = (mState == M_PRE && !mDir) || (mState == M_XFER && mDir);
        return {oo, io, pu, pd, (mState != M_IDLE), mLvl};
    endfunction

    task automatic modelReset();
        mState = M_IDLE; mPhase = 0; mRun = 0; mDir = 1'b0; mLvl = 1'b1;
    endtask

    // Advance the model by one clock edge with the given sampled inputs
    task automatic modelStep(input logic a, input logic d, input logic o);
        case (mState)
            M_IDLE: begin
                if (a || d) begin
                    mDir = !a;
                    mPhase = 0; mRun = 0;
                    mState = (mLvl == !mDir) ? M_PRE : M_ENTRY;
                end
            end
            M_PRE, M_XFER: begin
                mPhase++;
                if (mPhase == P) begin
                    mLvl = !mLvl;
                    mRun = 0;
                    mState = (mState == M_PRE) ? M_ENTRY : M_EXIT;
                end
            end
            M_ENTRY: begin
                mRun = o ? mRun + 1 : 0;
                if (mRun == S) begin mPhase = 0; mState = M_XFER; end
            end
            M_EXIT: begin
                mRun = !o ? mRun + 1 : 0;
                if (mRun == S) mState = M_IDLE;
            end
            default: mState = M_IDLE;
        endcase
    endtask

    task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s at %0t: got %b expected %b (outer,inner,up,down,busy,lvl)",
                     name, $time, got, exp);
        end
    endtask

    task automatic checkInvariants();
        nCompared++;
        if ((outer_open & inner_open) || (press_up & press_down) ||
            ((outer_open | inner_open) & (press_up | press_down))) begin
            nMismatched++;
            $display("FAIL invariants at %0t: got %b expected no overlap", $time, dutOut());
        end
    endtask

    // Drive one cycle; expected value comes from the table when useExp, else from the model
    task automatic step(input string name, input logic a, input logic d, input logic o,
                        input logic useExp, input logic [5:0] expV);
        arrive_req = a; depart_req = d; occupied = o;
        modelStep(a, d, o);
        expQ.push_back(useExp ? expV : modelOut());
        @(posedge clk);
        #1;
        if (expQ.size() == 0) begin
            nCompared++; nMismatched++;
            $display("FAIL %s: got empty scoreboard expected one entry", name);
        end else begin
            check(name, dutOut(), expQ.pop_front());
        end
        checkInvariants();
    endtask

    // Finish the current passage with a cooperative sensor, bounded
    task automatic finishPassage(input string name);
        int budget;
        budget = 0;
        while (mState != M_IDLE && budget < 100) begin
            step(name, 1'b0, 1'b0, (mState == M_ENTRY || mState == M_XFER), 1'b0, '0);
            budget++;
        end
        if (budget >= 100) begin
            nCompared++; nMismatched++;
            $display("FAIL %s: got no return to idle expected idle within 100 cycles", name);
        end
    endtask

    vec_t vecs[10];
    logic rOcc;

    initial begin
        // Arrive passage from level_hi=1, hand-derived for P=8, S=4
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1, 6'b000111};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 7, 6'b000111};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 2, 6'b100010};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 3, 6'b100010};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1, 6'b001010};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 7, 6'b001010};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 1, 6'b010011};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 3, 6'b010011};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 1, 6'b000001};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 2, 6'b000001};

        rst = 1'b1; arrive_req = 1'b0; depart_req = 1'b0; occupied = 1'b0;
        modelReset();
        @(posedge clk); @(posedge clk); #1;
        check("reset_state", dutOut(), 6'b000001);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                step($sformatf("arrive_vec%0d", i), vecs[i].a, vecs[i].d, vecs[i].o,
                     1'b1, vecs[i].exp);
            end
        end

        // Broken occupancy run during entry: close only after four consecutive ones
        step("toggle_req", 1'b1, 1'b0, 1'b0, 1'b0, '0);
        for (int k = 0; k < P; k++) step("toggle_pre", 1'b0, 1'b0, 1'b0, 1'b0, '0);
        for (int k = 0; k < 7; k++) begin
            step("toggle_occ", 1'b0, 1'b0, (k != 3), 1'b0, '0);
        end
        check("toggle_no_early_close", dutOut(), 6'b100010);
        step("toggle_close", 1'b0, 1'b0, 1'b1, 1'b0, '0);
        check("toggle_closed_press_up", dutOut(), 6'b001010);
        finishPassage("toggle_finish");

        // Depart at level_hi=1: no pre-adjust, inner door opens next cycle
        step("depart_req", 1'b0, 1'b1, 1'b0, 1'b0, '0);
        check("depart_inner_open", dutOut(), 6'b010011);
        finishPassage("depart_finish");
        check("depart_end_idle_low", dutOut(), 6'b000000);

        // Arrive at level_hi=0, then reset on the third transfer cycle
        step("rst_arrive", 1'b1, 1'b0, 1'b1, 1'b0, '0);
        for (int k = 0; k < S; k++) step("rst_entry", 1'b0, 1'b0, 1'b1, 1'b0, '0);
        for (int k = 0; k < 2; k++) step("rst_xfer", 1'b0, 1'b0, 1'b1, 1'b0, '0);
        check("rst_pre_xfer_up", dutOut(), 6'b001010);
        rst = 1'b1;
        #1;
        check("rst_immediate", dutOut(), 6'b000001);
        modelReset();
        @(negedge clk);
        rst = 1'b0;

        // Simultaneous requests after reset: arrive wins, pressure down first
        step("both_req", 1'b1, 1'b1, 1'b0, 1'b0, '0);
        check("both_req_press_down", dutOut(), 6'b000111);
        finishPassage("both_finish");

        // Random requests and sensor activity
        rOcc = 1'b0;
        for (int k = 0; k < 10000; k++) begin
            if ($urandom_range(0, 5) == 0) rOcc = ~rOcc;
            step("random", ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), rOcc,
                 1'b0, '0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
